// File: rtl/operand2_imm_encoder_pkg.sv
// Shared definitions for the operand2 immediate encoder and the operand2 shifter.
// The rotate helper is the single rotate definition used by both encode and decode.
package operand2_imm_encoder_pkg;

    localparam int OP2_IMM_W   = 8;
    localparam int OP2_ROT_W   = 4;
    localparam int OP2_DATA_W  = 32;
    localparam logic [OP2_ROT_W-1:0] OP2_ROT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Lossless 32-bit rotate-left; the upper half of the doubled word holds the result.
    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {v, v} << amt;
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/operand2_imm_encoder_rot_check.sv
// Combinational test of one rotation: does value ROL (2*k) fit in the low 8 bits?
// Also returns those low bits as the candidate imm8.
module operand2_rot_check
    import operand2_imm_encoder_pkg::*;
(
    input  logic [OP2_DATA_W-1:0] value,
    input  logic [OP2_ROT_W-1:0]  k,
    output logic                  hit,
    output logic [OP2_IMM_W-1:0]  imm8
);

    logic [OP2_DATA_W-1:0] cand;

    always_comb begin
        cand = rol32(value, {k, 1'b0});
        hit  = (cand[OP2_DATA_W-1:OP2_IMM_W] == '0);
        imm8 = cand[OP2_IMM_W-1:0];
    end

endmodule

// File: rtl/operand2_imm_encoder.sv
// Iterative operand2 immediate encoder: one rotation per clock, smallest hit wins,
// with valid/ready handshakes on the constant input and the result output.
module operand2_imm_encoder
    import operand2_imm_encoder_pkg::*;
#(
    parameter int IMM_W  = 8,
    parameter int ROT_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_encodable,
    output logic [ROT_W+IMM_W-1:0] out_operand,
    output logic [ROT_W-1:0]       out_rot_tried
);

    state_e                   state_q, state_d;
    logic [ROT_W-1:0]         k_q;
    logic [DATA_W-1:0]        value_q;
    logic                     hit;
    logic [IMM_W-1:0]         imm8;
    logic                     encodable_q;
    logic [ROT_W+IMM_W-1:0]   operand_q;
    logic [ROT_W-1:0]         rot_tried_q;

    operand2_rot_check u_rot_check (
        .value (value_q),
        .k     (k_q),
        .hit   (hit),
        .imm8  (imm8)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid)                  state_d = ST_SEARCH;
            ST_SEARCH: if (hit || k_q == OP2_ROT_MAX) state_d = ST_DONE;
            ST_DONE:   if (out_ready)                 state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Search counter, latched constant and result registers; results persist until overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q         <= '0;
            value_q     <= '0;
            encodable_q <= 1'b0;
            operand_q   <= '0;
            rot_tried_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        value_q <= in_value;
                        k_q     <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (hit) begin
                        operand_q   <= {k_q, imm8};
                        encodable_q <= 1'b1;
                        rot_tried_q <= k_q;
                    end else if (k_q == OP2_ROT_MAX) begin
                        operand_q   <= '0;
                        encodable_q <= 1'b0;
                        rot_tried_q <= k_q;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_encodable = encodable_q;
    assign out_operand   = operand_q;
    assign out_rot_tried = rot_tried_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Directed and randomized checks of operand2_imm_encoder against a decode-side brute-force model.
module tb_operand2_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        out_encodable;
    logic [11:0] out_operand;
    logic [3:0]  out_rot_tried;

    int n_vec;
    int n_miss;

    operand2_imm_encoder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_encodable (out_encodable),
        .out_operand   (out_operand),
        .out_rot_tried (out_rot_tried)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    // Try every one of the 4096 encodings in rotation order; first decode match is canonical.
    task automatic model(input logic [31:0] v, output logic enc, output logic [11:0] op,
                         output logic [3:0] rot, output int lat);
        enc = 1'b0;
        op  = 12'h000;
        rot = 4'd15;
        lat = 16;
        for (int r = 0; r < 16 && !enc; r++) begin
            for (int i = 0; i < 256; i++) begin
                if (ror32(32'(i), 2 * r) == v) begin
                    enc = 1'b1;
                    op  = {4'(r), 8'(i)};
                    rot = 4'(r);
                    lat = r + 1;
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input logic [31:0] v, input int bp, input bit noise);
        logic        e_enc;
        logic [11:0] e_op;
        logic [3:0]  e_rot;
        int          e_lat;
        int          lat;
        logic [11:0] d_op;
        model(v, e_enc, e_op, e_rot, e_lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_value  = v;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk);
        #1;
        in_valid = noise;
        if (noise) in_value = 32'h0000_0101;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
            chk("in_ready_search", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(e_lat));
        chk("encodable", 32'(out_encodable), 32'(e_enc));
        chk("operand", 32'(out_operand), 32'(e_op));
        chk("rot_tried", 32'(out_rot_tried), 32'(e_rot));
        if (out_encodable)
            chk("round_trip", ror32(32'(out_operand[7:0]), 2 * int'(out_operand[11:8])), v);
        for (int b = 0; b < bp; b++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_operand", 32'(out_operand), 32'(e_op));
            chk("bp_encodable", 32'(out_encodable), 32'(e_enc));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("hold_operand", 32'(out_operand), 32'(e_op));
        out_ready = 1'b0;
        d_op = e_op;
    endtask

    initial begin
        logic [31:0] v;
        n_vec     = 0;
        n_miss    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_encodable", 32'(out_encodable), 32'd0);
        chk("rst_operand", 32'(out_operand), 32'd0);
        chk("rst_rot_tried", 32'(out_rot_tried), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_vec(32'h0000_00FF, 0, 1'b0);
        run_vec(32'hFF00_0000, 0, 1'b1);
        run_vec(32'hF000_000F, 2, 1'b0);
        run_vec(32'h0000_03FC, 0, 1'b0);
        run_vec(32'h0000_0101, 5, 1'b1);
        run_vec(32'h0000_0000, 1, 1'b0);
        run_vec(32'h0003_FC00, 0, 1'b0);

        // Abort mid-search of an unencodable constant once k has reached 7.
        @(negedge clk);
        in_value  = 32'h0000_0101;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("pre_abort_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_encodable", 32'(out_encodable), 32'd0);
        chk("abort_operand", 32'(out_operand), 32'd0);
        chk("abort_rot_tried", 32'(out_rot_tried), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(32'h0000_00FF, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 1)
                v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            else
                v = $urandom;
            run_vec(v, int'($urandom_range(0, 3)), (i % 5 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/operand2_imm_encoder.md
Name: operand2_imm_encoder

Overview:
- Inverse of the data-processing operand2 immediate decode. Takes a 32-bit constant and iteratively searches for the 12-bit shifter_operand encoding {rot[3:0], imm8[7:0]}, defined by value == imm8 ROR (2*rot).
- Sits beside the operand2 shifter. Used by the instruction-build / constant-load path to decide whether a constant fits an immediate or must come from a register.
- Multi-cycle: tests one rotation per clock. Valid/ready handshake on both sides.

Parameters:
- IMM_W, 8: width of the immediate field. The design supports only 8.
- ROT_W, 4: width of the rotate field. 2**ROT_W rotations are tried, with a step of 2 bits.
- DATA_W, 32: width of the constant. Must equal 32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a constant is presented on in_value
- in_ready  output  1  encoder can accept a constant; high only in IDLE
- in_value  input  32  constant to encode
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_encodable  output  1  1 = constant fits the immediate form; 0 = it does not
- out_operand  output  12  {rot, imm8}; 12'h000 when not encodable
- out_rot_tried  output  4  index of the last rotation evaluated (debug/perf)

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - state=IDLE, k=0, value register=0
  - in_ready=1, out_valid=0, out_encodable=0, out_operand=0, out_rot_tried=0
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_value, set k=0, go to SEARCH.
- SEARCH (in_ready=0, out_valid=0). Each cycle:
  - Compute cand = value ROL (2*k), a 32-bit rotate with no loss of bits.
  - Hit = (cand[31:8]==0).
  - On hit: register out_operand={k, cand[7:0]}, out_encodable=1, out_rot_tried=k; go to DONE.
  - On miss with k==15: out_operand=0, out_encodable=0, out_rot_tried=15; go to DONE.
  - Otherwise: k=k+1.
  - The smallest k that hits is always the one reported, so the encoding is canonical.
- DONE:
  - out_valid=1. Outputs stay stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle, state goes to IDLE, in_ready=1 next cycle.
  - Outputs hold their last values until the next result. Only out_valid qualifies them.
- Latency:
  - Hit at rotation k: out_valid is high k+1 cycles after the accept edge. Range is 1 to 16.
  - Not encodable: 16 cycles.
  - Minimum issue interval: latency + 2 cycles (DONE handshake cycle, then IDLE accept).
- Boundaries:
  - in_value=0 hits at k=0 with operand 000.
  - in_valid is ignored outside IDLE; the upstream holds it.
  - out_ready high on the same cycle out_valid first rises completes the transfer in that cycle.
  - reset_n low mid-SEARCH or mid-DONE aborts immediately and returns to IDLE. No partial result is emitted.
  - Never round-trip-ambiguous: decoding out_operand with the shifter rule (imm8 ROR 2*rot) must return in_value exactly when out_encodable=1.

Decomposition:
- Shared package: state encoding (IDLE/SEARCH/DONE), IMM_W/ROT_W constants, and an rol32 function. The rotate function is shared with the operand2 shifter so encode and decode use one rotate definition.
- One natural sub-module: operand2_rot_check. It is combinational: (value, k) -> (hit, imm8). The FSM, counter and handshake stay in the top.

Test Plan:
- in_value=32'h000000FF, out_ready=1 -> out_valid 1 cycle after accept; encodable=1, operand=12'h0FF, rot_tried=0.
- in_value=32'hFF000000 -> operand=12'h4FF, latency 5, encodable=1.
- in_value=32'hF000000F -> operand=12'h2FF (k=2, latency 3). Also in_value=32'h000003FC -> operand=12'hFFF, latency 16.
- in_value=32'h00000101 -> latency 16; encodable=0, operand=12'h000, rot_tried=15.
- Backpressure: out_ready held low for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; accept on release, in_ready=1 the next cycle. A new in_valid during SEARCH is not accepted.
- Drop reset_n at k=7 while encoding 32'h00000101 -> immediate IDLE, all outputs 0. After release, 32'h000000FF encodes correctly. Random sweep: every encodable result decodes back to in_value via the shifter rule.
